// File: rtl/retire_sync_n.sv
// -----------------------------------------------------------------------------
// retire_sync_n
//
// Lock-step retire aligner for N copies of a core in the relational
// contract-checking harness. Each copy gets one registered clock enable. A
// copy that retires is frozen (enable low) until every active copy has
// retired the same instruction index. Then all copies are released together
// and a single aligned retire pulse goes to the observers.
//
// Optional feature (compile-time macro RETIRE_SYNC_TIMEOUT_EN):
//   A partial retire may wait at most MAX_WAIT cycles. If the other copies
//   have still not retired by then, the block enters a terminal DESYNC state.
//   In DESYNC all enables are low, desync_o is set, and only reset exits.
//   Without the macro there is no wait counter, partial retires wait
//   indefinitely, and desync_o is tied low.
//
// Ports:
//   clk_i         harness clock
//   rst_ni        asynchronous active-low reset
//   active_i      [N_CORES] channel takes part in alignment
//   retire_i      [N_CORES] per-copy retire strobe
//   clk_en_o      [N_CORES] registered per-copy clock enable
//   stalled_o     [N_CORES] copy has retired and is waiting for the others
//   retire_o      one-cycle aligned-retire pulse
//   retire_cnt_o  [CNT_W] saturating count of aligned retires
//   desync_o      sticky divergence flag
// -----------------------------------------------------------------------------
module retire_sync_n #(
  parameter int N_CORES  = 2,
  parameter int CNT_W    = 16,
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_CORES-1:0] active_i,
  input  logic [N_CORES-1:0] retire_i,
  output logic [N_CORES-1:0] clk_en_o,
  output logic [N_CORES-1:0] stalled_o,
  output logic               retire_o,
  output logic [CNT_W-1:0]   retire_cnt_o,
  output logic               desync_o
);

  // Reject configurations that cannot work at elaboration time.
  if (N_CORES < 1 || MAX_WAIT < 1 || MAX_WAIT > (1 << WAIT_W) - 1) begin : g_param_check
    $error("retire_sync_n: illegal N_CORES / MAX_WAIT / WAIT_W combination");
  end

  logic [N_CORES-1:0] held_q;   // copies that have retired this round
  logic [N_CORES-1:0] acc;      // retires accepted this cycle
  logic [N_CORES-1:0] held_d;
  logic               done;     // every active copy has now retired

  // A retire counts only if the copy was actually clocked and is active.
  // Dropping a channel's active bit also forgets that it retired.
  assign acc    = retire_i & clk_en_o & active_i;
  assign held_d = (held_q | acc) & active_i;
  assign done   = (|active_i) && (&(held_d | ~active_i));

  // The held set is itself the registered stall indication.
  assign stalled_o = held_q;

`ifdef RETIRE_SYNC_TIMEOUT_EN
  typedef enum logic {
    SYNC   = 1'b0,
    DESYNC = 1'b1
  } state_e;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_e            state_q;
  logic [WAIT_W-1:0] wait_q;
  logic              timeout_hit;

  // Fires only while someone is really waiting. A release in the same cycle
  // (done) takes priority over the limit.
  assign timeout_hit = (held_q != '0) && (held_d != '0) && !done && (wait_q == WAIT_LAST);
`else
  assign desync_o = 1'b0;
`endif

  // NOTE: every register here uses non-blocking assignments. All the next
  // state is computed from the pre-edge values, so the order of the
  // statements inside the block does not matter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held_q       <= '0;
      clk_en_o     <= '0;
      retire_o     <= 1'b0;
      retire_cnt_o <= '0;
`ifdef RETIRE_SYNC_TIMEOUT_EN
      state_q      <= SYNC;
      wait_q       <= '0;
      desync_o     <= 1'b0;
`endif
    end else begin
`ifdef RETIRE_SYNC_TIMEOUT_EN
      if (state_q == DESYNC) begin
        // Terminal state: all copies frozen and the counter frozen.
        held_q   <= '0;
        clk_en_o <= '0;
        retire_o <= 1'b0;
      end else
`endif
      if (done) begin
        // Release all copies together with the pulse. There is no dead cycle.
        held_q   <= '0;
        clk_en_o <= active_i;
        retire_o <= 1'b1;
        if (retire_cnt_o != '1) begin
          retire_cnt_o <= retire_cnt_o + 1'b1;
        end
`ifdef RETIRE_SYNC_TIMEOUT_EN
        wait_q   <= '0;
`endif
      end
`ifdef RETIRE_SYNC_TIMEOUT_EN
      else if (timeout_hit) begin
        state_q  <= DESYNC;
        desync_o <= 1'b1;
        held_q   <= '0;
        clk_en_o <= '0;
        retire_o <= 1'b0;
      end
`endif
      else begin
        held_q   <= held_d;
        clk_en_o <= active_i & ~held_d;
        retire_o <= 1'b0;
`ifdef RETIRE_SYNC_TIMEOUT_EN
        // Count only the cycles that follow a registered partial retire.
        if (held_d == '0) begin
          wait_q <= '0;
        end else if (held_q != '0) begin
          wait_q <= wait_q + 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_retire_sync_n.sv
// -----------------------------------------------------------------------------
// tb_retire_sync_n
//
// Self-checking bench for retire_sync_n with N_CORES=2, CNT_W=2 (so that
// saturation is easy to reach), and MAX_WAIT=4. Directed scenarios come
// first, followed by a randomized run. In the randomized run every output is
// compared each cycle against a behavioural model of the alignment rules.
// Inputs are driven and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_retire_sync_n;

  localparam int N        = 2;
  localparam int CNT_W    = 2;
  localparam int WAIT_W   = 8;
  localparam int MAX_WAIT = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef RETIRE_SYNC_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic             clk_i  = 1'b0;
  logic             rst_ni = 1'b1;
  logic [N-1:0]     active_i = '0;
  logic [N-1:0]     retire_i = '0;
  logic [N-1:0]     clk_en_o;
  logic [N-1:0]     stalled_o;
  logic             retire_o;
  logic [CNT_W-1:0] retire_cnt_o;
  logic             desync_o;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  retire_sync_n #(
    .N_CORES (N),
    .CNT_W   (CNT_W),
    .WAIT_W  (WAIT_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .active_i    (active_i),
    .retire_i    (retire_i),
    .clk_en_o    (clk_en_o),
    .stalled_o   (stalled_o),
    .retire_o    (retire_o),
    .retire_cnt_o(retire_cnt_o),
    .desync_o    (desync_o)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model: per-copy flags and plain integer counters.
  // ---------------------------------------------------------------------------
  bit m_waiting [N];   // copy has retired and waits for the others
  bit m_running [N];   // copy is being clocked
  bit m_pulse;
  int m_count;
  int m_stall_cycles;
  bit m_broken;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_waiting[i] = 1'b0;
      m_running[i] = 1'b0;
    end
    m_pulse        = 1'b0;
    m_count        = 0;
    m_stall_cycles = 0;
    m_broken       = 1'b0;
  endtask

  // Advance one clock using the inputs the DUT has just sampled.
  task automatic model_step();
    bit after [N];
    bit any_active, everyone_in, anyone_after, anyone_before;
    if (m_broken) begin
      m_pulse = 1'b0;
    end else begin
      any_active = 0; everyone_in = 1; anyone_after = 0; anyone_before = 0;
      for (int i = 0; i < N; i++) begin
        after[i] = active_i[i] && (m_waiting[i] || (retire_i[i] && m_running[i]));
        if (active_i[i]) any_active = 1;
        if (active_i[i] && !after[i]) everyone_in = 0;
        if (after[i]) anyone_after = 1;
        if (m_waiting[i]) anyone_before = 1;
      end
      if (any_active && everyone_in) begin
        for (int i = 0; i < N; i++) begin
          m_waiting[i] = 1'b0;
          m_running[i] = active_i[i];
        end
        m_pulse = 1'b1;
        m_stall_cycles = 0;
        if (m_count < CNT_MAX) m_count++;
      end else if (TIMEOUT && anyone_before && anyone_after && m_stall_cycles == MAX_WAIT - 1) begin
        for (int i = 0; i < N; i++) begin
          m_waiting[i] = 1'b0;
          m_running[i] = 1'b0;
        end
        m_pulse  = 1'b0;
        m_broken = 1'b1;
      end else begin
        for (int i = 0; i < N; i++) begin
          m_waiting[i] = after[i];
          m_running[i] = active_i[i] && !after[i];
        end
        m_pulse = 1'b0;
        if (!anyone_after) m_stall_cycles = 0;
        else if (anyone_before) m_stall_cycles++;
      end
    end
  endtask

  function automatic logic [N-1:0] exp_en();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_running[i];
    return v;
  endfunction

  function automatic logic [N-1:0] exp_stall();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_waiting[i];
    return v;
  endfunction

  // One clock: the DUT samples at the posedge, then we return on the negedge.
  task automatic tick();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
  endtask

  // Assert reset at once, then release it on the next falling edge.
  task automatic do_reset(input logic [N-1:0] act);
    rst_ni   = 1'b0;
    active_i = act;
    retire_i = '0;
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #2;
    rst_ni   = 1'b0;
    active_i = 2'b11;
    retire_i = 2'b11;
    #1;
    tests_run++; if (clk_en_o !== 2'b00) begin tests_failed++; $display("FAIL rst_en got %b want 00", clk_en_o); end
    tests_run++; if (retire_cnt_o !== 2'd0 || retire_o !== 1'b0 || stalled_o !== 2'b00 || desync_o !== 1'b0) begin
      tests_failed++; $display("FAIL rst_outs got cnt=%0d ret=%b st=%b ds=%b want 0", retire_cnt_o, retire_o, stalled_o, desync_o); end
    retire_i = '0;
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    tests_run++; if (clk_en_o !== 2'b11) begin tests_failed++; $display("FAIL rel_en got %b want 11", clk_en_o); end
    tests_run++; if (retire_o !== 1'b0 || stalled_o !== 2'b00 || retire_cnt_o !== 2'd0 || desync_o !== 1'b0) begin
      tests_failed++; $display("FAIL rel_outs got ret=%b st=%b cnt=%0d ds=%b want 0", retire_o, stalled_o, retire_cnt_o, desync_o); end
  endtask

  task automatic test_stall_release();
    do_reset(2'b11);
    tick();
    retire_i = 2'b01; tick();
    retire_i = 2'b00;
    tests_run++; if (clk_en_o !== 2'b10 || stalled_o !== 2'b01) begin tests_failed++; $display("FAIL stall_t1 got en=%b st=%b want 10/01", clk_en_o, stalled_o); end
    tests_run++; if (retire_o !== 1'b0) begin tests_failed++; $display("FAIL stall_t1_ret got %b want 0", retire_o); end
    tick();
    tests_run++; if (clk_en_o !== 2'b10 || stalled_o !== 2'b01) begin tests_failed++; $display("FAIL stall_t2 got en=%b st=%b want 10/01", clk_en_o, stalled_o); end
    retire_i = 2'b10; tick();
    retire_i = 2'b00;
    tests_run++; if (retire_o !== 1'b1 || clk_en_o !== 2'b11) begin tests_failed++; $display("FAIL release got ret=%b en=%b want 1/11", retire_o, clk_en_o); end
    tests_run++; if (retire_cnt_o !== 2'd1 || stalled_o !== 2'b00) begin tests_failed++; $display("FAIL release_cnt got cnt=%0d st=%b want 1/00", retire_cnt_o, stalled_o); end
    tick();
    tests_run++; if (retire_o !== 1'b0 || clk_en_o !== 2'b11) begin tests_failed++; $display("FAIL pulse_end got ret=%b en=%b want 0/11", retire_o, clk_en_o); end
  endtask

  task automatic test_back_to_back();
    do_reset(2'b11);
    tick();
    for (int k = 1; k <= 2; k++) begin
      retire_i = 2'b11; tick();
      tests_run++; if (retire_o !== 1'b1 || clk_en_o !== 2'b11 || stalled_o !== 2'b00) begin
        tests_failed++; $display("FAIL simul_%0d got ret=%b en=%b st=%b want 1/11/00", k, retire_o, clk_en_o, stalled_o); end
      tests_run++; if (retire_cnt_o !== CNT_W'(k)) begin tests_failed++; $display("FAIL simul_cnt_%0d got %0d want %0d", k, retire_cnt_o, k); end
    end
    retire_i = 2'b00;
  endtask

  task automatic test_timeout();
    do_reset(2'b11);
    tick();
    retire_i = 2'b01; tick();          // now at t+1
    retire_i = 2'b00;
    for (int k = 2; k <= 4; k++) begin
      tick();
      tests_run++; if (desync_o !== 1'b0 || clk_en_o !== 2'b10) begin
        tests_failed++; $display("FAIL wait_t%0d got ds=%b en=%b want 0/10", k, desync_o, clk_en_o); end
    end
    tick();                            // t+5
`ifdef RETIRE_SYNC_TIMEOUT_EN
    tests_run++; if (desync_o !== 1'b1 || clk_en_o !== 2'b00 || stalled_o !== 2'b00) begin
      tests_failed++; $display("FAIL desync got ds=%b en=%b st=%b want 1/00/00", desync_o, clk_en_o, stalled_o); end
    retire_i = 2'b11;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) active_i = 2'b01;
      tick();
      tests_run++; if (retire_o !== 1'b0 || clk_en_o !== 2'b00 || retire_cnt_o !== 2'd0 || desync_o !== 1'b1) begin
        tests_failed++; $display("FAIL desync_hold got ret=%b en=%b cnt=%0d ds=%b want 0/00/0/1", retire_o, clk_en_o, retire_cnt_o, desync_o); end
    end
`else
    for (int k = 0; k < 20; k++) begin
      tick();
      tests_run++; if (desync_o !== 1'b0 || clk_en_o !== 2'b10 || stalled_o !== 2'b01) begin
        tests_failed++; $display("FAIL no_timeout got ds=%b en=%b st=%b want 0/10/01", desync_o, clk_en_o, stalled_o); end
    end
    retire_i = 2'b10; tick();
    tests_run++; if (retire_o !== 1'b1 || clk_en_o !== 2'b11) begin tests_failed++; $display("FAIL late_release got ret=%b en=%b want 1/11", retire_o, clk_en_o); end
`endif
    retire_i = 2'b00;
  endtask

  task automatic test_active_drop();
    do_reset(2'b11);
    tick();
    retire_i = 2'b01; tick();
    retire_i = 2'b00;
    active_i = 2'b01; tick();
    tests_run++; if (retire_o !== 1'b1 || clk_en_o !== 2'b01 || stalled_o !== 2'b00) begin
      tests_failed++; $display("FAIL drop_release got ret=%b en=%b st=%b want 1/01/00", retire_o, clk_en_o, stalled_o); end
    active_i = 2'b11; tick();
    tests_run++; if (clk_en_o !== 2'b11 || retire_o !== 1'b0) begin tests_failed++; $display("FAIL readd got en=%b ret=%b want 11/0", clk_en_o, retire_o); end
    active_i = 2'b00; retire_i = 2'b11; tick();
    tests_run++; if (clk_en_o !== 2'b00 || retire_o !== 1'b0) begin tests_failed++; $display("FAIL none_active got en=%b ret=%b want 00/0", clk_en_o, retire_o); end
    retire_i = 2'b00;
  endtask

  task automatic test_saturation();
    int want;
    do_reset(2'b11);
    tick();
    for (int k = 1; k <= 5; k++) begin
      retire_i = 2'b11; tick();
      want = (k < CNT_MAX) ? k : CNT_MAX;
      tests_run++; if (retire_cnt_o !== CNT_W'(want) || retire_o !== 1'b1) begin
        tests_failed++; $display("FAIL sat_%0d got cnt=%0d ret=%b want %0d/1", k, retire_cnt_o, retire_o, want); end
    end
    retire_i = 2'b01; tick();
    retire_i = 2'b00;
    #2;
    rst_ni = 1'b0;
    #1;
    tests_run++; if (clk_en_o !== 2'b00 || stalled_o !== 2'b00 || retire_o !== 1'b0 || retire_cnt_o !== 2'd0 || desync_o !== 1'b0) begin
      tests_failed++; $display("FAIL async_rst got en=%b st=%b ret=%b cnt=%0d ds=%b want 0", clk_en_o, stalled_o, retire_o, retire_cnt_o, desync_o); end
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_random();
    do_reset(2'b11);
    for (int cyc = 0; cyc < 800; cyc++) begin
      tick();
      tests_run++; if (clk_en_o !== exp_en()) begin tests_failed++; $display("FAIL rand_en c%0d got %b want %b", cyc, clk_en_o, exp_en()); end
      tests_run++; if (stalled_o !== exp_stall()) begin tests_failed++; $display("FAIL rand_stall c%0d got %b want %b", cyc, stalled_o, exp_stall()); end
      tests_run++; if (retire_o !== m_pulse) begin tests_failed++; $display("FAIL rand_ret c%0d got %b want %b", cyc, retire_o, m_pulse); end
      tests_run++; if (retire_cnt_o !== CNT_W'(m_count)) begin tests_failed++; $display("FAIL rand_cnt c%0d got %0d want %0d", cyc, retire_cnt_o, m_count); end
      tests_run++; if (desync_o !== m_broken) begin tests_failed++; $display("FAIL rand_desync c%0d got %b want %b", cyc, desync_o, m_broken); end
      if ($urandom_range(0, 59) == 0) do_reset(N'($urandom_range(1, (1 << N) - 1)));
      if ($urandom_range(0, 15) == 0) active_i = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) retire_i[i] = ($urandom_range(0, 99) < 35);
    end
    retire_i = '0;
  endtask

  initial begin
    test_reset();
    test_stall_release();
    test_back_to_back();
    test_timeout();
    test_active_drop();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/retire_sync_n.md
Name: retire_sync_n

Overview:
- N-channel successor to the two-copy clock synchroniser in the relational contract-checking harness.
- Drives one registered clock-enable per core copy. The top level derives each copy's clock from its enable.
- Stalls any copy that has retired until every active copy has retired the same instruction index, then emits one aligned retire pulse to the attacker/contract observers.
- Adds per-channel activity masking, a saturating retire counter, and an optional divergence timeout.

Parameters:
- N_CORES, 2, number of core copies (≥1).
- CNT_W, 16, width of the aligned-retire counter.
- WAIT_W, 8, width of the stall-wait counter.
- MAX_WAIT, 64, cycles a partial retire may wait before desync is declared (1..2^WAIT_W-1).

Ports:
- clk_i  in  1  harness clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- active_i  in  N_CORES  channel participates in alignment. Inactive channels are never enabled and are ignored.
- retire_i  in  N_CORES  per-copy retire strobe from the core.
- clk_en_o  out  N_CORES  registered per-copy clock enable.
- stalled_o  out  N_CORES  copy has retired and is held awaiting the others.
- retire_o  out  1  one-cycle aligned-retire pulse.
- retire_cnt_o  out  CNT_W  number of aligned retires, saturating.
- desync_o  out  1  sticky divergence flag.

Behaviour:
- Reset values (async, rst_ni=0):
  - held_q=0, clk_en_o=0, stalled_o=0, retire_o=0, retire_cnt_o=0, wait_cnt=0, desync_o=0.
  - State is SYNC.
- First cycle after reset release: clk_en_o = active_i.
- Accepted retire:
  - acc = retire_i & clk_en_o & active_i.
  - A retire_i bit on a disabled or inactive channel is ignored.
- held_d = (held_q | acc) & active_i. Deasserting active_i on a held channel clears its bit.
- done = (active_i != 0) && ((held_d | ~active_i) all ones).
- State SYNC, each cycle:
  - If done: held_q←0, retire_o←1 next cycle, clk_en_o←active_i, wait_cnt←0, retire_cnt_o←retire_cnt_o+1 (holds at all-ones).
  - Else: held_q←held_d, clk_en_o←active_i & ~held_d, retire_o←0.
  - stalled_o = held_q.
- Latency:
  - A retire at cycle t drops that channel's enable at t+1.
  - A completing retire at cycle t gives retire_o=1 and all enables high at t+1. There is no dead cycle.
- Simultaneous retire of all active channels in one cycle: no stall; retire_o at t+1, enables stay high.
- active_i all zero: clk_en_o=0, no retire_o, wait_cnt held at 0.
- Newly asserted active_i bit: channel is enabled next cycle unless in DESYNC.
- Single active channel: every accepted retire produces retire_o at t+1, with no stall.

Optional Feature:
- Macro: RETIRE_SYNC_TIMEOUT_EN.
- Defined:
  - wait_cnt increments each SYNC cycle with held_q≠0 and !done, and clears on done or when held_d==0.
  - When wait_cnt==MAX_WAIT-1 and still !done: next cycle state←DESYNC, desync_o←1, clk_en_o←0, stalled_o←0.
  - DESYNC ignores retire_i and active_i, keeps retire_cnt_o frozen, and exits only on reset.
  - done in the same cycle as the limit wins: normal release, no desync.
- Undefined:
  - No wait counter; desync_o tied to 0.
  - Partial retires wait indefinitely; DESYNC state absent.

Test Plan (N_CORES=2, MAX_WAIT=4, timeout enabled unless noted):
1. Reset release with active_i=2'b11 → clk_en_o=2'b11 the cycle after; all other outputs 0.
2. retire_i=2'b01 at t, retire_i=2'b10 at t+2:
   - clk_en_o=2'b10 and stalled_o=2'b01 for t+1..t+2.
   - retire_o=1 and clk_en_o=2'b11 at t+3.
   - retire_cnt_o=1.
3. retire_i=2'b11 at t → retire_o=1 at t+1, clk_en_o never drops, stalled_o stays 0.
4. retire_i=2'b01 at t, copy 1 never retires → desync_o=1 and clk_en_o=2'b00 at t+5. Later retire_i=2'b11 gives no retire_o. Without RETIRE_SYNC_TIMEOUT_EN: enable stays 2'b10 indefinitely and desync_o stays 0.
5. Copy 0 held, then active_i←2'b01 → release: retire_o=1 next cycle, clk_en_o=2'b01.
6. CNT_W=2, five aligned retires → retire_cnt_o sequence 1,2,3,3,3. Asserting rst_ni=0 while held clears all outputs asynchronously.
